// File: rtl/crane_pkg.sv
// Shared constants for the crane-game round controller: state encoding,
// output widths and the saturating credit update.
package crane_pkg;

    localparam int TIME_W   = 8;
    localparam int CREDIT_W = 4;
    localparam int PRIZE_W  = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;
    localparam logic [1:0] ST_RESULT  = 2'd3;

    // Apply the coin and the start debit together, then saturate the final
    // value, so a same-cycle coin and start nets to zero even at the cap.
    // A debit only happens when cur is non-zero, so no underflow.
    function automatic logic [CREDIT_W-1:0] credit_next(
        input logic [CREDIT_W-1:0] cur,
        input logic                add,
        input logic                sub,
        input logic [CREDIT_W-1:0] max_c
    );
        logic [CREDIT_W:0] sum;
        sum = {1'b0, cur} + {{CREDIT_W{1'b0}}, add} - {{CREDIT_W{1'b0}}, sub};
        if (sum > {1'b0, max_c}) credit_next = max_c;
        else                     credit_next = sum[CREDIT_W-1:0];
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick generator. Counts 0..CYCLES_PER_SEC-1 while run is high
// and flags the last count; clear forces the count back to 0.
module sec_tick_gen #(
    parameter int CYCLES_PER_SEC = 100000000
) (
    input  logic clock_100Mhz,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic sec_tick
);

    localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sec_tick = run && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise advance and wrap while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)    cnt_d = '0;
        else if (run) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/round_controller.sv
// Crane-game round sequencer: credits, round countdown, claw gating, drop
// command and win/lose result. Optional macro FREE_PLAY_EN lets start_btn
// begin a round without checking or consuming credits.
//
// state      | meaning
// IDLE       | waiting for start_btn (with credit unless free play)
// PLAYING    | claw enabled, countdown running
// DROP       | drop_cmd issued, waiting for claw_done
// RESULT     | win shown for RESULT_HOLD_S seconds
module round_controller
    import crane_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 100000000,
    parameter int ROUND_TIME     = 20,
    parameter int RESULT_HOLD_S  = 3,
    parameter int MAX_CREDITS    = 9
) (
    input  logic                clock_100Mhz,
    input  logic                reset_n,
    input  logic                coin_in,
    input  logic                start_btn,
    input  logic                drop_btn,
    input  logic                claw_done,
    input  logic                prize_in,
    output logic [1:0]          state,
    output logic [TIME_W-1:0]   time_left,
    output logic [CREDIT_W-1:0] credits,
    output logic                claw_enable,
    output logic                drop_cmd,
    output logic                win,
    output logic [PRIZE_W-1:0]  prizes
);

    localparam logic [TIME_W-1:0]   ROUND_T = TIME_W'(ROUND_TIME);
    localparam logic [3:0]          HOLD_T  = 4'(RESULT_HOLD_S);
    localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDITS);

    logic [1:0]          state_q, state_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [PRIZE_W-1:0]  prizes_q, prizes_d;
    logic [3:0]          hold_q, hold_d;
    logic                win_q, win_d;
    logic                claw_en_q, claw_en_d;
    logic                drop_cmd_q, drop_cmd_d;
    logic                credit_ok, credit_use, start_ok, sec_tick, tick_run, tick_clear;

`ifdef FREE_PLAY_EN
    assign credit_ok  = 1'b1;
    assign credit_use = 1'b0;
`else
    assign credit_ok  = (credits_q != '0);
    assign credit_use = 1'b1;
`endif

    // Start decision uses the pre-coin credit value.
    assign start_ok   = start_btn && (state_q == ST_IDLE) && credit_ok;
    assign tick_run   = (state_q == ST_PLAYING) || (state_q == ST_RESULT);
    assign tick_clear = (state_d != state_q);

    sec_tick_gen #(.CYCLES_PER_SEC(CYCLES_PER_SEC)) u_sec_tick (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .clear        (tick_clear),
        .run          (tick_run),
        .sec_tick     (sec_tick)
    );

    // Round sequencing and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        win_d    = win_q;
        prizes_d = prizes_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_PLAYING;
                    time_d  = ROUND_T;
                end
            end
            ST_PLAYING: begin
                if (sec_tick && (time_q != '0)) time_d = time_q - 1'b1;
                if (drop_btn || (time_q == '0)) state_d = ST_DROP;
            end
            ST_DROP: begin
                if (claw_done) begin
                    state_d = ST_RESULT;
                    win_d   = prize_in;
                    hold_d  = HOLD_T;
                    if (prize_in) prizes_d = prizes_q + 1'b1;
                end
            end
            default: begin
                if (sec_tick) begin
                    if (hold_q <= 4'd1) state_d = ST_IDLE;
                    else                hold_d  = hold_q - 1'b1;
                end
            end
        endcase
        credits_d  = credit_next(credits_q, coin_in, start_ok && credit_use, MAX_C);
        claw_en_d  = (state_d == ST_PLAYING);
        drop_cmd_d = (state_d == ST_DROP) && (state_q != ST_DROP);
    end

    // State and output registers; reset mid-round forfeits the round.
    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            credits_q  <= '0;
            prizes_q   <= '0;
            hold_q     <= '0;
            win_q      <= 1'b0;
            claw_en_q  <= 1'b0;
            drop_cmd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            credits_q  <= credits_d;
            prizes_q   <= prizes_d;
            hold_q     <= hold_d;
            win_q      <= win_d;
            claw_en_q  <= claw_en_d;
            drop_cmd_q <= drop_cmd_d;
        end
    end

    assign state       = state_q;
    assign time_left   = time_q;
    assign credits     = credits_q;
    assign claw_enable = claw_en_q;
    assign drop_cmd    = drop_cmd_q;
    assign win         = win_q;
    assign prizes      = prizes_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller with CYCLES_PER_SEC=10, ROUND_TIME=3,
// RESULT_HOLD_S=2, MAX_CREDITS=9. Honours FREE_PLAY_EN like the design.
module tb_round_controller;

    localparam int CPS  = 10;
    localparam int RT   = 3;
    localparam int HOLD = 2;
    localparam int MAXC = 9;
`ifdef FREE_PLAY_EN
    localparam bit FREE = 1'b1;
`else
    localparam bit FREE = 1'b0;
`endif

    localparam int P_COIN = 0, P_START = 1, P_DROP = 2, P_DONE = 3, P_COINSTART = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       coin_in = 1'b0, start_btn = 1'b0, drop_btn = 1'b0;
    logic       claw_done = 1'b0, prize_in = 1'b0;
    logic [1:0] state;
    logic [7:0] time_left, prizes;
    logic [3:0] credits;
    logic       claw_enable, drop_cmd, win;

    int errors = 0;
    int checks = 0;

    round_controller #(
        .CYCLES_PER_SEC(CPS), .ROUND_TIME(RT),
        .RESULT_HOLD_S(HOLD), .MAX_CREDITS(MAXC)
    ) dut (
        .clock_100Mhz (clk),
        .reset_n      (reset_n),
        .coin_in      (coin_in),
        .start_btn    (start_btn),
        .drop_btn     (drop_btn),
        .claw_done    (claw_done),
        .prize_in     (prize_in),
        .state        (state),
        .time_left    (time_left),
        .credits      (credits),
        .claw_enable  (claw_enable),
        .drop_cmd     (drop_cmd),
        .win          (win),
        .prizes       (prizes)
    );

    always #5 clk = ~clk;

    // Behavioural model: rounds are described by how long the game has been
    // in the current phase (m_n) rather than by a tick counter.
    int m_state, m_n, m_time, m_cred, m_prizes;
    bit m_win, m_drop, m_claw;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_n = 0; m_time = 0; m_cred = 0;
            m_prizes = 0; m_win = 0; m_drop = 0; m_claw = 0;
        end else begin
            int ns, c;
            bit start_ok;
            ns = m_state;
            start_ok = start_btn && (m_state == 0) && (FREE || m_cred > 0);
            c = m_cred + int'(coin_in) - ((start_ok && !FREE) ? 1 : 0);
            if (c > MAXC) c = MAXC;
            case (m_state)
                0: if (start_ok) begin ns = 1; m_time = RT; end
                1: begin
                    if (drop_btn || m_time == 0) ns = 2;
                    if ((m_n % CPS) == CPS - 1 && m_time > 0) m_time = m_time - 1;
                end
                2: if (claw_done) begin
                    ns = 3; m_win = prize_in;
                    if (prize_in) m_prizes = (m_prizes + 1) % 256;
                end
                default: if (m_n == HOLD * CPS - 1) ns = 0;
            endcase
            m_drop = (ns == 2) && (m_state != 2);
            m_claw = (ns == 1);
            m_n = (ns == m_state) ? m_n + 1 : 0;
            m_state = ns;
            m_cred = c;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            logic [24:0] act, exp;
            act = {state, time_left, credits, claw_enable, drop_cmd, win, prizes};
            exp = {m_state[1:0], m_time[7:0], m_cred[3:0], m_claw, m_drop, m_win, m_prizes[7:0]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model t=%0t got st=%0d tl=%0d cr=%0d ce=%0b dc=%0b w=%0b pz=%0d want st=%0d tl=%0d cr=%0d ce=%0b dc=%0b w=%0b pz=%0d",
                         $time, state, time_left, credits, claw_enable, drop_cmd, win, prizes,
                         m_state, m_time, m_cred, m_claw, m_drop, m_win, m_prizes);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input int which, input bit prize);
        @(posedge clk); #2;
        case (which)
            P_COIN:      coin_in = 1'b1;
            P_START:     start_btn = 1'b1;
            P_DROP:      drop_btn = 1'b1;
            P_DONE:      begin claw_done = 1'b1; prize_in = prize; end
            default:     begin coin_in = 1'b1; start_btn = 1'b1; end
        endcase
        @(posedge clk); #2;
        coin_in = 1'b0; start_btn = 1'b0; drop_btn = 1'b0; claw_done = 1'b0;
    endtask

    task automatic wait_state(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == 2'(target)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_state got %0d want %0d after %0d cycles", state, target, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_credits", credits, 0);
        chk("rst_time", time_left, 0);
        chk("rst_prizes", prizes, 0);
        chk("rst_drop_cmd", drop_cmd, 0);
        #1 reset_n = 1'b1;

        // Round 1: two coins, start, let the clock run out, win.
        pulse(P_COIN, 0); pulse(P_COIN, 0);
        @(negedge clk);
        chk("two_coins", credits, 2);
        pulse(P_START, 0);
        @(negedge clk);
        chk("r1_state", state, 1);
        chk("r1_credits", credits, FREE ? 2 : 1);
        chk("r1_time", time_left, 3);
        chk("r1_claw", claw_enable, 1);
        repeat (10) @(negedge clk);
        chk("r1_time_at10", time_left, 2);
        repeat (20) @(negedge clk);
        chk("r1_time_at30", time_left, 0);
        chk("r1_still_play", state, 1);
        @(negedge clk);
        chk("r1_drop_state", state, 2);
        chk("r1_drop_cmd", drop_cmd, 1);
        chk("r1_claw_off", claw_enable, 0);
        @(negedge clk);
        chk("r1_drop_cmd_once", drop_cmd, 0);
        pulse(P_DONE, 1);
        @(negedge clk);
        chk("r1_result", state, 3);
        chk("r1_win", win, 1);
        chk("r1_prizes", prizes, 1);
        repeat (19) @(negedge clk);
        chk("r1_hold", state, 3);
        @(negedge clk);
        chk("r1_idle", state, 0);

        // Round 2: early drop at time_left 2, lose.
        pulse(P_START, 0);
        @(negedge clk);
        chk("r2_state", state, 1);
        chk("r2_credits", credits, FREE ? 2 : 0);
        repeat (12) @(negedge clk);
        pulse(P_DROP, 0);
        @(negedge clk);
        chk("r2_drop_state", state, 2);
        chk("r2_time_frozen", time_left, 2);
        pulse(P_DONE, 0);
        @(negedge clk);
        chk("r2_win", win, 0);
        chk("r2_prizes", prizes, 1);
        wait_state(0, 30);
        pulse(P_DROP, 0); pulse(P_DONE, 1);
        @(negedge clk);
        chk("idle_ignores", state, 0);
        chk("idle_win_held", win, 0);

`ifdef FREE_PLAY_EN
        // Only the default build has credits 0 here; free play still credits 2.
        pulse(P_START, 0);
        @(negedge clk);
        chk("free_start", state, 1);
        chk("free_credits", credits, 2);
        pulse(P_DROP, 0);
        wait_state(2, 5);
        pulse(P_DONE, 0);
        wait_state(0, 30);
`else
        pulse(P_START, 0);
        @(negedge clk);
        chk("no_credit_start", state, 0);
`endif

        for (int i = 0; i < 12; i++) pulse(P_COIN, 0);
        @(negedge clk);
        chk("saturate", credits, 9);

        // Reset mid-round.
        pulse(P_START, 0);
        repeat (5) @(negedge clk);
        chk("pre_reset_state", state, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_credits", credits, 0);
        chk("mid_rst_prizes", prizes, 0);
        chk("mid_rst_claw", claw_enable, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", state, 0);

        // Coin + start at credits 1, drop in the final-tick cycle.
        pulse(P_COIN, 0);
        pulse(P_COINSTART, 0);
        @(negedge clk);
        chk("cs_state", state, 1);
        chk("cs_credits", credits, FREE ? 2 : 1);
        repeat (28) @(negedge clk);
        chk("ft_time", time_left, 1);
        pulse(P_DROP, 0);
        @(negedge clk);
        chk("ft_state", state, 2);
        chk("ft_time0", time_left, 0);
        chk("ft_drop_cmd", drop_cmd, 1);
        @(negedge clk);
        chk("ft_drop_once", drop_cmd, 0);
        pulse(P_DONE, 1);
        @(negedge clk);
        chk("ft_prizes", prizes, 1);
        wait_state(0, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
